// File: rtl/inst_dispatcher.sv
// Instruction dispatcher: buffers host instructions in a circular FIFO and issues
// them one at a time to an execution controller, tracking completions and timeouts.
module inst_dispatcher #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_inst,
    input  logic                       run,
    output logic                       ctrl_start,
    output logic [31:0]                ctrl_inst,
    input  logic                       ctrl_valid,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [15:0]                done_count,
    output logic                       timeout_err,
    input  logic                       clr_err
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t          state_q;
    logic [31:0]     mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [TW-1:0]   tcnt_q;
    logic [15:0]     done_q;
    logic            terr_q;
    logic            start_q;
    logic [31:0]     inst_q;
    logic            busy_q;
    logic            push, pop;

    assign in_ready    = (count_q < CW'(DEPTH));
    assign push        = in_valid && in_ready;
    // The head is consumed in the single ISSUE cycle; ISSUE is only entered when non-empty.
    assign pop         = (state_q == S_ISSUE);
    assign fifo_count  = count_q;
    assign done_count  = done_q;
    assign timeout_err = terr_q;
    assign ctrl_start  = start_q;
    assign ctrl_inst   = inst_q;
    assign busy        = busy_q;

    always_comb begin
        wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Storage array carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= in_inst;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            tcnt_q  <= '0;
            done_q  <= '0;
            terr_q  <= 1'b0;
            start_q <= 1'b0;
            inst_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            start_q <= 1'b0;
            inst_q  <= '0;
            // A timeout set below overrides this clear.
            if (clr_err) begin
                terr_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (run && (count_q != '0)) begin
                        state_q <= S_ISSUE;
                        start_q <= 1'b1;
                        inst_q  <= mem_q[rptr_q];
                        busy_q  <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                    tcnt_q  <= '0;
                end
                S_WAIT: begin
                    if (ctrl_valid) begin
                        done_q  <= done_q + 16'd1;
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
                        terr_q  <= 1'b1;
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
